// File: rtl/edf_pkg.sv
// Shared EDF interrupt-controller package: FSM states, timestamp width, deadline ordering.
// EDF_ARB_WRAP_EN selects wrap-aware (signed difference) ordering instead of plain unsigned.
package edf_pkg;

   localparam int TsWidthDef = 64;
   localparam int TsMaxWidth = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      VALID   = 2'd2,
      CLAIMED = 2'd3
   } edf_state_e;

   function automatic logic [TsMaxWidth-1:0] ts_mask(input int unsigned w);
      return {TsMaxWidth{1'b1}} >> (TsMaxWidth - w);
   endfunction

   // True when deadline a is strictly earlier than deadline b, both w bits wide.
   function automatic logic dl_before(input logic [TsMaxWidth-1:0] a,
                                      input logic [TsMaxWidth-1:0] b,
                                      input int unsigned           w);
      logic [TsMaxWidth:0] diff;
      diff = {1'b0, a & ts_mask(w)} - {1'b0, b & ts_mask(w)};
`ifdef EDF_ARB_WRAP_EN
      return 1'(diff >> (w - 1));
`else
      return diff[TsMaxWidth];
`endif
   endfunction

endpackage

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first arbiter: scans one source per cycle, presents the winner, runs claim/complete.
// Deadline ordering is wrap-aware when EDF_ARB_WRAP_EN is defined, plain unsigned otherwise.
module edf_arbiter
   import edf_pkg::*;
#(
   parameter int NumSrc  = 8,
   parameter int TsWidth = TsWidthDef,
   parameter int IdWidth = $clog2(NumSrc)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NumSrc-1:0]         ip_i,
   input  logic [NumSrc*TsWidth-1:0] dl_i,
   input  logic                      claim_i,
   input  logic                      complete_i,
   input  logic [IdWidth-1:0]        complete_id_i,
   output logic                      irq_o,
   output logic [IdWidth-1:0]        irq_id_o,
   output logic [TsWidth-1:0]        irq_dl_o,
   output logic [NumSrc-1:0]         ip_clr_o,
   output logic                      busy_o
);

   edf_state_e           state_d, state_q;
   logic [IdWidth-1:0]   idx_d, idx_q;
   logic                 best_valid_d, best_valid_q;
   logic [IdWidth-1:0]   best_id_d, best_id_q;
   logic [TsWidth-1:0]   best_dl_d, best_dl_q;
   logic [IdWidth-1:0]   claimed_id_d, claimed_id_q;
   logic [NumSrc-1:0]    ip_prev_d, ip_prev_q;
   logic                 irq_d, irq_q;
   logic [IdWidth-1:0]   irq_id_d, irq_id_q;
   logic [TsWidth-1:0]   irq_dl_d, irq_dl_q;
   logic [NumSrc-1:0]    ip_clr_d, ip_clr_q;
   logic                 busy_d, busy_q;

   logic                 cur_ip;
   logic [TsWidth-1:0]   cur_dl;
   logic [TsMaxWidth-1:0] cur_dl_ext;
   logic [TsMaxWidth-1:0] best_dl_ext;
   logic                 take;
   logic                 ip_changed;
   logic                 last_idx;

   // Select the source under evaluation; the one comparator is shared across all sources.
   always_comb begin
      cur_ip = 1'b0;
      cur_dl = '0;
      for (int i = 0; i < NumSrc; i++) begin
         if (idx_q == IdWidth'(i)) begin
            cur_ip = ip_i[i];
            cur_dl = dl_i[i*TsWidth +: TsWidth];
         end else begin
            cur_ip = cur_ip;
            cur_dl = cur_dl;
         end
      end
   end

   // Candidate decision: strict comparison so equal deadlines keep the lower index.
   always_comb begin
      cur_dl_ext                = '0;
      best_dl_ext               = '0;
      cur_dl_ext[TsWidth-1:0]   = cur_dl;
      best_dl_ext[TsWidth-1:0]  = best_dl_q;
      take       = cur_ip & (~best_valid_q | dl_before(cur_dl_ext, best_dl_ext, TsWidth));
      ip_changed = (ip_i != ip_prev_q);
      last_idx   = (idx_q == IdWidth'(NumSrc - 1));
      ip_prev_d  = ip_i;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      best_valid_d = best_valid_q;
      best_id_d    = best_id_q;
      best_dl_d    = best_dl_q;
      claimed_id_d = claimed_id_q;
      irq_d        = irq_q;
      irq_id_d     = irq_id_q;
      irq_dl_d     = irq_dl_q;
      ip_clr_d     = '0;
      busy_d       = busy_q;

      case (state_q)
         IDLE: begin
            if (ip_i != '0) begin
               state_d      = SCAN;
               idx_d        = '0;
               best_valid_d = 1'b0;
            end else begin
               state_d      = IDLE;
            end
         end

         SCAN: begin
            if (ip_changed) begin
               idx_d        = '0;
               best_valid_d = 1'b0;
            end else begin
               if (take) begin
                  best_id_d    = idx_q;
                  best_dl_d    = cur_dl;
                  best_valid_d = 1'b1;
               end else begin
                  best_valid_d = best_valid_q;
               end
               if (last_idx) begin
                  idx_d = '0;
                  if (take || best_valid_q) begin
                     state_d  = VALID;
                     irq_d    = 1'b1;
                     irq_id_d = take ? idx_q : best_id_q;
                     irq_dl_d = take ? cur_dl : best_dl_q;
                  end else begin
                     state_d  = IDLE;
                  end
               end else begin
                  idx_d = idx_q + IdWidth'(1);
               end
            end
         end

         VALID: begin
            // Claim wins over a simultaneous change of the pending set.
            if (claim_i) begin
               state_d            = CLAIMED;
               claimed_id_d       = best_id_q;
               ip_clr_d[best_id_q] = 1'b1;
               irq_d              = 1'b0;
               busy_d             = 1'b1;
            end else if (ip_changed) begin
               state_d      = SCAN;
               idx_d        = '0;
               best_valid_d = 1'b0;
               irq_d        = 1'b0;
            end else begin
               state_d      = VALID;
            end
         end

         CLAIMED: begin
            if (complete_i && (complete_id_i == claimed_id_q)) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
               best_valid_d = 1'b0;
            end else begin
               state_d      = CLAIMED;
            end
         end

         default: begin
            state_d      = IDLE;
            idx_d        = '0;
            best_valid_d = 1'b0;
            irq_d        = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         best_valid_q <= 1'b0;
         best_id_q    <= '0;
         best_dl_q    <= '0;
         claimed_id_q <= '0;
         ip_prev_q    <= '0;
         irq_q        <= 1'b0;
         irq_id_q     <= '0;
         irq_dl_q     <= '0;
         ip_clr_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         best_valid_q <= best_valid_d;
         best_id_q    <= best_id_d;
         best_dl_q    <= best_dl_d;
         claimed_id_q <= claimed_id_d;
         ip_prev_q    <= ip_prev_d;
         irq_q        <= irq_d;
         irq_id_q     <= irq_id_d;
         irq_dl_q     <= irq_dl_d;
         ip_clr_q     <= ip_clr_d;
         busy_q       <= busy_d;
      end
   end

   assign irq_o    = irq_q;
   assign irq_id_o = irq_id_q;
   assign irq_dl_o = irq_dl_q;
   assign ip_clr_o = ip_clr_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_edf_arbiter.sv
// Self-checking bench for edf_arbiter with four sources and 64-bit deadlines.
module tb_edf_arbiter;

   localparam int NumSrc  = 4;
   localparam int TsWidth = 64;
   localparam int IdWidth = 2;

   logic                      clk_i = 1'b0;
   logic                      rst_ni;
   logic [NumSrc-1:0]         ip_i;
   logic [NumSrc*TsWidth-1:0] dl_i;
   logic                      claim_i;
   logic                      complete_i;
   logic [IdWidth-1:0]        complete_id_i;
   logic                      irq_o;
   logic [IdWidth-1:0]        irq_id_o;
   logic [TsWidth-1:0]        irq_dl_o;
   logic [NumSrc-1:0]         ip_clr_o;
   logic                      busy_o;

   logic [TsWidth-1:0] dl_arr [NumSrc];

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [TsWidth-1:0] dl;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   assign dl_i = {dl_arr[3], dl_arr[2], dl_arr[1], dl_arr[0]};

   always #5 clk_i = ~clk_i;

   edf_arbiter #(.NumSrc(NumSrc), .TsWidth(TsWidth), .IdWidth(IdWidth)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .ip_i         (ip_i),
      .dl_i         (dl_i),
      .claim_i      (claim_i),
      .complete_i   (complete_i),
      .complete_id_i(complete_id_i),
      .irq_o        (irq_o),
      .irq_id_o     (irq_id_o),
      .irq_dl_o     (irq_dl_o),
      .ip_clr_o     (ip_clr_o),
      .busy_o       (busy_o)
   );

   task automatic wait_irq(output int cycles, output bit timed_out);
      cycles    = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         cycles++;
         if (irq_o === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain();
      ip_i       = '0;
      claim_i    = 1'b0;
      complete_i = 1'b0;
      repeat (12) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_ni = 1'b0;
      ip_i = '0; claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
      for (int i = 0; i < NumSrc; i++) dl_arr[i] = '0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (irq_o !== 1'b0 || irq_id_o !== '0 || irq_dl_o !== '0 || ip_clr_o !== '0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs irq=%0b id=%0d dl=%0d clr=%b busy=%0b required all zero",
                  irq_o, irq_id_o, irq_dl_o, ip_clr_o, busy_o);
      end
      rst_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_irq irq=%0b required 0", irq_o);
      end
      e = '0;
   endtask

   task automatic test_single_claim_complete();
      int cyc; bit to; exp_t e;
      dl_arr[2] = 64'd100;
      ip_i = 4'b0100;
      sb_q.push_back(exp_t'{id: 2'd2, dl: 64'd100});
      wait_irq(cyc, to);
      checks++;
      if (to || cyc != 5) begin
         errors++;
         $display("FAIL single_latency cycles=%0d timeout=%0b required 5", cyc, to);
      end
      e = sb_q.pop_front();
      checks++;
      if (irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL single_winner id=%0d dl=%0d required id=%0d dl=%0d", irq_id_o, irq_dl_o, e.id, e.dl);
      end
      claim_i = 1'b1;
      @(posedge clk_i); #1;
      claim_i = 1'b0;
      ip_i    = '0;
      checks++;
      if (ip_clr_o !== 4'b0100 || busy_o !== 1'b1 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL claim_pulse clr=%b busy=%0b irq=%0b required clr=0100 busy=1 irq=0", ip_clr_o, busy_o, irq_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (ip_clr_o !== 4'b0000 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL claim_pulse_end clr=%b busy=%0b required clr=0000 busy=1", ip_clr_o, busy_o);
      end
      complete_i = 1'b1; complete_id_i = 2'd1;
      @(posedge clk_i); #1;
      complete_i = 1'b0;
      @(posedge clk_i); #1;
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL complete_wrong_id busy=%0b required 1", busy_o);
      end
      complete_i = 1'b1; complete_id_i = 2'd2;
      ip_i = 4'b0001; dl_arr[0] = 64'd7;
      sb_q.push_back(exp_t'{id: 2'd0, dl: 64'd7});
      @(posedge clk_i); #1;
      complete_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL complete_ok busy=%0b required 0", busy_o);
      end
      wait_irq(cyc, to);
      checks++;
      if (to || cyc != 5) begin
         errors++;
         $display("FAIL post_complete_latency cycles=%0d timeout=%0b required 5", cyc, to);
      end
      e = sb_q.pop_front();
      checks++;
      if (irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL post_complete_winner id=%0d dl=%0d required id=%0d dl=%0d", irq_id_o, irq_dl_o, e.id, e.dl);
      end
      drain();
   endtask

   task automatic test_earliest_and_tie();
      int cyc; bit to; exp_t e;
      dl_arr[0] = 64'd20; dl_arr[1] = 64'd30; dl_arr[2] = 64'd10; dl_arr[3] = 64'd40;
      ip_i = 4'b1111;
      sb_q.push_back(exp_t'{id: 2'd2, dl: 64'd10});
      wait_irq(cyc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL earliest_wins id=%0d dl=%0d timeout=%0b required id=%0d dl=%0d", irq_id_o, irq_dl_o, to, e.id, e.dl);
      end
      drain();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL drop_on_change irq=%0b required 0", irq_o);
      end
      dl_arr[0] = 64'd90; dl_arr[1] = 64'd50; dl_arr[2] = 64'd60; dl_arr[3] = 64'd50;
      ip_i = 4'b1010;
      sb_q.push_back(exp_t'{id: 2'd1, dl: 64'd50});
      wait_irq(cyc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL tie_lower_index id=%0d dl=%0d timeout=%0b required id=%0d dl=%0d", irq_id_o, irq_dl_o, to, e.id, e.dl);
      end
      drain();
   endtask

   task automatic test_restart();
      int cyc; bit to; exp_t e;
      dl_arr[0] = 64'd9; dl_arr[1] = 64'd5; dl_arr[2] = 64'd1; dl_arr[3] = 64'd1;
      ip_i = 4'b0001;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      ip_i = 4'b0011;
      sb_q.push_back(exp_t'{id: 2'd1, dl: 64'd5});
      wait_irq(cyc, to);
      checks++;
      if (to || cyc != 5) begin
         errors++;
         $display("FAIL restart_latency cycles=%0d timeout=%0b required 5", cyc, to);
      end
      e = sb_q.pop_front();
      checks++;
      if (irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL restart_winner id=%0d dl=%0d required id=%0d dl=%0d", irq_id_o, irq_dl_o, e.id, e.dl);
      end
      drain();
   endtask

   task automatic test_wrap();
      int cyc; bit to; exp_t e;
      dl_arr[0] = 64'hFFFF_FFFF_FFFF_FFF6;
      dl_arr[1] = 64'd5;
      ip_i = 4'b0011;
`ifdef EDF_ARB_WRAP_EN
      sb_q.push_back(exp_t'{id: 2'd0, dl: 64'hFFFF_FFFF_FFFF_FFF6});
`else
      sb_q.push_back(exp_t'{id: 2'd1, dl: 64'd5});
`endif
      wait_irq(cyc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL wrap_order id=%0d dl=%0h timeout=%0b required id=%0d dl=%0h", irq_id_o, irq_dl_o, to, e.id, e.dl);
      end
      drain();
   endtask

   task automatic test_reset_mid_op();
      int cyc; bit to; exp_t e;
      dl_arr[3] = 64'd1;
      ip_i = 4'b1000;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (irq_o !== 1'b0 || irq_id_o !== '0 || irq_dl_o !== '0 || ip_clr_o !== '0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_scan irq=%0b id=%0d dl=%0d clr=%b busy=%0b required all zero",
                  irq_o, irq_id_o, irq_dl_o, ip_clr_o, busy_o);
      end
      ip_i = '0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      dl_arr[2] = 64'd100;
      ip_i = 4'b0100;
      wait_irq(cyc, to);
      claim_i = 1'b1;
      @(posedge clk_i); #1;
      claim_i = 1'b0;
      ip_i = '0;
      checks++;
      if (to || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL claimed_before_reset busy=%0b timeout=%0b required busy=1", busy_o, to);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if (irq_o !== 1'b0 || irq_id_o !== '0 || irq_dl_o !== '0 || ip_clr_o !== '0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_claimed irq=%0b id=%0d dl=%0d clr=%b busy=%0b required all zero",
                  irq_o, irq_id_o, irq_dl_o, ip_clr_o, busy_o);
      end
      dl_arr[1] = 64'd3;
      ip_i = 4'b0010;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      sb_q.push_back(exp_t'{id: 2'd1, dl: 64'd3});
      wait_irq(cyc, to);
      checks++;
      if (to || cyc != 5) begin
         errors++;
         $display("FAIL idle_after_reset cycles=%0d timeout=%0b required 5", cyc, to);
      end
      e = sb_q.pop_front();
      checks++;
      if (irq_id_o !== e.id || irq_dl_o !== e.dl) begin
         errors++;
         $display("FAIL after_reset_winner id=%0d dl=%0d required id=%0d dl=%0d", irq_id_o, irq_dl_o, e.id, e.dl);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single_claim_complete();
      test_earliest_and_tie();
      test_restart();
      test_wrap();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
